// File: rtl/data_sync_pkg.sv
// Shared definitions for the REQ/ACK receive-side CDC controller:
// FSM state encoding and the legal synchronizer depth range.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOLD     = 2'b01,
        ACK_WAIT = 2'b11
    } rx_state_e;

    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 4;

endpackage

// File: rtl/req_sync_chain.sv
// NUM_STAGES-deep 1-bit synchronizer for the incoming request level.
// All stages clear asynchronously; the output is the last stage, ungated.
module req_sync_chain
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic req_async,
    output logic req_s
);

    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_depth
        $error("req_sync_chain: NUM_STAGES=%0d outside legal range %0d..%0d",
               NUM_STAGES, MIN_STAGES, MAX_STAGES);
    end

    logic [NUM_STAGES-1:0] stages;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[NUM_STAGES-2:0], req_async};
        end
    end

    assign req_s = stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_hs_rx.sv
// Destination-domain receiver for a 4-phase REQ/ACK bus crossing.
// Optional PROTOCOL_CHECK_EN adds a sticky PROT_ERR flag for request misuse.
module data_sync_hs_rx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 REQ_ASYNC,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 ACK,
    output logic                 BUSY
`ifdef PROTOCOL_CHECK_EN
    ,
    output logic                 PROT_ERR
`endif
);

    logic                 req_s;
    rx_state_e            state;
    rx_state_e            state_d;
    logic                 capture;
    logic [BUS_WIDTH-1:0] sync_bus_q;

    req_sync_chain #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .req_async(REQ_ASYNC),
        .req_s    (req_s)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            sync_bus_q <= '0;
        end else begin
            state <= state_d;
            if (capture) begin
                sync_bus_q <= UNSYNC_BUS;
            end
        end
    end

    // Downstream handshake: a word moves on any edge where DATA_VALID and
    // DATA_READY are both high; DATA_VALID then holds until that edge and
    // SYNC_BUS stays frozen while valid. A request withdrawn in HOLD is
    // ignored so the held word is still delivered before acknowledging.
    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (DATA_READY) begin
                    state_d = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ACK is bit 1 of the state flop itself, so it is glitch-free to the source.
    assign ACK        = state[1];
    assign DATA_VALID = (state == HOLD);
    assign BUSY       = (state != IDLE);
    assign SYNC_BUS   = sync_bus_q;

`ifdef PROTOCOL_CHECK_EN
    logic req_was_low_q;
    logic prot_err_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            req_was_low_q <= 1'b0;
            prot_err_q    <= 1'b0;
        end else begin
            req_was_low_q <= ~req_s;
            if ((state == HOLD && !req_s) ||
                (state == ACK_WAIT && req_s && req_was_low_q)) begin
                prot_err_q <= 1'b1;
            end
        end
    end

    assign PROT_ERR = prot_err_q;
`endif

endmodule

// File: tb/tb_data_sync_hs_rx.sv
// Directed bench for data_sync_hs_rx (BUS_WIDTH=8, NUM_STAGES=2) with a
// scoreboard of expected transfer words checked at each valid/ready handshake.
module tb_data_sync_hs_rx;

    localparam int W = 8;

    logic         CLK;
    logic         RST_n;
    logic         REQ_ASYNC;
    logic [W-1:0] UNSYNC_BUS;
    logic [W-1:0] SYNC_BUS;
    logic         DATA_VALID;
    logic         DATA_READY;
    logic         ACK;
    logic         BUSY;
`ifdef PROTOCOL_CHECK_EN
    logic         PROT_ERR;
`endif

    logic [W-1:0] exp_q[$];
    int           pass_cnt = 0;
    int           fail_cnt = 0;
    int           total_cnt = 0;
    int           xfer_cnt = 0;

    data_sync_hs_rx #(
        .BUS_WIDTH (W),
        .NUM_STAGES(2)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .REQ_ASYNC (REQ_ASYNC),
        .UNSYNC_BUS(UNSYNC_BUS),
        .SYNC_BUS  (SYNC_BUS),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .ACK       (ACK),
        .BUSY      (BUSY)
`ifdef PROTOCOL_CHECK_EN
        ,
        .PROT_ERR  (PROT_ERR)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // scoreboard: a word is delivered on the edge following a negedge that sees valid&ready
    always @(negedge CLK) begin
        if (RST_n && DATA_VALID && DATA_READY) begin
            xfer_cnt++;
            chk("xfer_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                chk("xfer_data", 32'(SYNC_BUS), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver: one complete 4-phase handshake with random ready timing
    task automatic do_xfer(input logic [W-1:0] data);
        UNSYNC_BUS = data;
        REQ_ASYNC  = 1'b1;
        DATA_READY = 1'b0;
        exp_q.push_back(data);
        for (int i = 0; i < 40 && !ACK; i++) begin
            DATA_READY = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk("b2b_ack_rise", 32'(ACK), 32'd1);
        UNSYNC_BUS = W'($urandom_range(0, 255));
        REQ_ASYNC  = 1'b0;
        DATA_READY = 1'($urandom_range(0, 1));
        for (int i = 0; i < 20 && ACK; i++) begin
            tick(1);
        end
        chk("b2b_ack_fall", 32'(ACK), 32'd0);
        chk("b2b_idle", 32'(BUSY), 32'd0);
        DATA_READY = 1'b0;
        tick(1);
    endtask

    initial begin
        int xfers_before;

        RST_n      = 1'b0;
        REQ_ASYNC  = 1'b0;
        UNSYNC_BUS = '0;
        DATA_READY = 1'b0;
        tick(2);
        chk("rst_outputs", {SYNC_BUS, DATA_VALID, ACK, BUSY}, 32'd0);
        RST_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_outputs", {SYNC_BUS, DATA_VALID, ACK, BUSY}, 32'd0);
        end

        // 2: ready already high, basic latency
        UNSYNC_BUS = 8'hA5;
        REQ_ASYNC  = 1'b1;
        DATA_READY = 1'b1;
        exp_q.push_back(8'hA5);
        tick(1);
        chk("lat_e1_valid", 32'(DATA_VALID), 32'd0);
        tick(1);
        chk("lat_e2_valid", 32'(DATA_VALID), 32'd0);
        tick(1);
        chk("lat_e3_valid", 32'(DATA_VALID), 32'd1);
        chk("lat_e3_bus", 32'(SYNC_BUS), 32'hA5);
        chk("lat_e3_ack", 32'(ACK), 32'd0);
        tick(1);
        chk("lat_e4_valid", 32'(DATA_VALID), 32'd0);
        chk("lat_e4_ack", 32'(ACK), 32'd1);
        REQ_ASYNC = 1'b0;
        tick(1);
        chk("ackfall_e1", 32'(ACK), 32'd1);
        tick(1);
        chk("ackfall_e2", 32'(ACK), 32'd1);
        tick(1);
        chk("ackfall_e3", 32'(ACK), 32'd0);
        chk("ackfall_busy", 32'(BUSY), 32'd0);
        chk("bus_kept", 32'(SYNC_BUS), 32'hA5);
        DATA_READY = 1'b0;
        tick(1);

        // 3: backpressure, bus change while holding
        UNSYNC_BUS = 8'h3C;
        REQ_ASYNC  = 1'b1;
        exp_q.push_back(8'h3C);
        tick(3);
        chk("bp_valid", 32'(DATA_VALID), 32'd1);
        chk("bp_bus", 32'(SYNC_BUS), 32'h3C);
        UNSYNC_BUS = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_hold", {SYNC_BUS, DATA_VALID, ACK}, {8'h3C, 1'b1, 1'b0});
        end
        DATA_READY = 1'b1;
        tick(1);
        chk("bp_ack", 32'(ACK), 32'd1);
        chk("bp_valid_clr", 32'(DATA_VALID), 32'd0);
        REQ_ASYNC = 1'b0;
        tick(3);
        chk("bp_ack_fall", 32'(ACK), 32'd0);
        DATA_READY = 1'b0;
        tick(1);

        // 4: three back-to-back handshakes
        xfers_before = xfer_cnt;
        do_xfer(8'h01);
        do_xfer(8'h02);
        do_xfer(8'h03);
        chk("b2b_count", 32'(xfer_cnt - xfers_before), 32'd3);
        chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset while holding
        UNSYNC_BUS = 8'h77;
        REQ_ASYNC  = 1'b1;
        DATA_READY = 1'b0;
        exp_q.push_back(8'h77);
        tick(3);
        chk("rst_pre_hold", {SYNC_BUS, DATA_VALID}, {8'h77, 1'b1});
        #2;
        RST_n = 1'b0;
        #1;
        chk("rst_async", {SYNC_BUS, DATA_VALID, ACK, BUSY}, 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h77);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        tick(1);
        chk("rst_rel_e1", 32'(DATA_VALID), 32'd0);
        tick(1);
        chk("rst_rel_e2", 32'(DATA_VALID), 32'd0);
        tick(1);
        chk("rst_rel_e3", {SYNC_BUS, DATA_VALID}, {8'h77, 1'b1});
        DATA_READY = 1'b1;
        tick(1);
        chk("rst_rel_ack", 32'(ACK), 32'd1);
        REQ_ASYNC  = 1'b0;
        DATA_READY = 1'b0;
        tick(3);
        chk("rst_rel_ack_fall", 32'(ACK), 32'd0);
        tick(1);

        // 6: request withdrawn while holding
        UNSYNC_BUS = 8'h5A;
        REQ_ASYNC  = 1'b1;
        exp_q.push_back(8'h5A);
        tick(3);
        chk("viol_hold", {SYNC_BUS, DATA_VALID}, {8'h5A, 1'b1});
        REQ_ASYNC = 1'b0;
        tick(3);
        chk("viol_still_valid", {SYNC_BUS, DATA_VALID, ACK}, {8'h5A, 1'b1, 1'b0});
`ifdef PROTOCOL_CHECK_EN
        chk("viol_prot_err", 32'(PROT_ERR), 32'd1);
`endif
        DATA_READY = 1'b1;
        tick(1);
        chk("viol_ack", {DATA_VALID, ACK}, {1'b0, 1'b1});
        DATA_READY = 1'b0;
        tick(1);
        chk("viol_idle", {ACK, BUSY}, 32'd0);
`ifdef PROTOCOL_CHECK_EN
        tick(2);
        chk("viol_prot_sticky", 32'(PROT_ERR), 32'd1);
`endif

        chk("total_xfers", 32'(xfer_cnt), 32'd7);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_sync_hs_rx.md
Name: data_sync_hs_rx

Overview:
- Receive-side controller for a 4-phase REQ/ACK clock-domain crossing of a multi-bit bus.
- Lives in the destination clock domain and uses a multi-stage synchronizer on the incoming request only.
- Captures the quasi-static bus once the request is synchronized, presents it downstream with a valid/ready handshake, and then drives ACK back to the source domain.
- Sits between a source-domain producer (e.g. register file / UART front end) and a destination-domain consumer.

Parameters:
- BUS_WIDTH, 8: width of the transferred data bus.
- NUM_STAGES, 2: synchronizer depth on REQ_ASYNC. Legal range 2..4; elaboration error outside this range.

Ports:
- CLK  input  1  destination-domain clock.
- RST_n  input  1  asynchronous, active-low reset.
- REQ_ASYNC  input  1  source-domain request level (4-phase), unsynchronized.
- UNSYNC_BUS  input  BUS_WIDTH  source data. The source holds it stable from before REQ_ASYNC rises until it sees ACK high.
- SYNC_BUS  output  BUS_WIDTH  registered captured data.
- DATA_VALID  output  1  captured data available downstream.
- DATA_READY  input  1  downstream accepts data.
- ACK  output  1  registered acknowledge level to the source domain.
- BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RST_n is asynchronous and active-low: all flops clear immediately on assertion and release synchronously.
- Reset values: SYNC_BUS=0, DATA_VALID=0, ACK=0, BUSY=0, all synchronizer flops 0, FSM=IDLE.
- Synchronizer: REQ_ASYNC passes through NUM_STAGES flops; the last stage output is req_s. Only req_s is used by the FSM.
- FSM states and transitions:
  - IDLE: ACK=0, DATA_VALID=0. If req_s=1, register UNSYNC_BUS into SYNC_BUS, set DATA_VALID=1, go to HOLD.
  - HOLD: DATA_VALID=1, SYNC_BUS frozen. On an edge with DATA_READY=1, clear DATA_VALID, set ACK=1, go to ACK_WAIT.
  - ACK_WAIT: ACK=1. When req_s=0, clear ACK and go to IDLE.
- Latency:
  - Count the first CLK edge that samples REQ_ASYNC=1 as edge 1. req_s is high after edge NUM_STAGES; DATA_VALID and SYNC_BUS update at edge NUM_STAGES+1.
  - ACK rises on the edge that completes the valid/ready transfer.
  - ACK falls NUM_STAGES+1 edges after the first edge that samples REQ_ASYNC=0, minimum.
- Handshake boundaries:
  - DATA_READY already high when DATA_VALID rises: DATA_VALID stays high exactly one cycle.
  - DATA_READY is ignored in IDLE and ACK_WAIT.
  - SYNC_BUS keeps its last value after the transfer until the next capture.
  - UNSYNC_BUS is sampled exactly once per transfer, at the IDLE->HOLD edge. Changes at any other time have no effect.
  - req_s falling while in HOLD (protocol violation): ignored. Data remains valid, and the FSM proceeds to ACK_WAIT, then IDLE, on the next edge.
  - New REQ_ASYNC rise while in ACK_WAIT: impossible under 4-phase protocol. req_s=1 there simply holds the FSM in ACK_WAIT.
  - Back-to-back transfers: at least one IDLE cycle between ACK fall and the next capture.
- Reset mid-operation: any state returns to IDLE and all outputs clear. The source must observe ACK=0 and restart its handshake.

Optional Feature:
- Macro PROTOCOL_CHECK_EN.
- Defined:
  - Adds output PROT_ERR (1 bit, reset 0), sticky until reset.
  - PROT_ERR is set on an edge where the FSM is in HOLD and req_s=0, i.e. the request was withdrawn before ACK.
  - Also set in ACK_WAIT if req_s returns high within one cycle after having been low. This tracking needs a one-bit register.
- Undefined: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package data_sync_pkg:
  - state encoding IDLE=2'b00, HOLD=2'b01, ACK_WAIT=2'b11;
  - localparams MIN_STAGES=2, MAX_STAGES=4.
- One sub-module, req_sync_chain: a parameterized NUM_STAGES 1-bit flop chain with asynchronous active-low reset clearing to 0. It has no output gating by reset.
- The FSM, capture register and handshake live in the top module.

Test Plan (BUS_WIDTH=8, NUM_STAGES=2):
1. Reset, then hold RST_n high with REQ_ASYNC=0 for 10 cycles -> SYNC_BUS=8'h00, DATA_VALID=0, ACK=0, BUSY=0 throughout.
2. UNSYNC_BUS=8'hA5, raise REQ_ASYNC before edge 1, DATA_READY=1 -> DATA_VALID high for exactly one cycle after edge 3 and SYNC_BUS=8'hA5. ACK rises at edge 4; drop REQ -> ACK falls 3 edges later.
3. Capture 8'h3C with DATA_READY=0 for 5 cycles, change UNSYNC_BUS to 8'hFF meanwhile -> DATA_VALID stays high, SYNC_BUS stays 8'h3C, ACK=0. Raise DATA_READY -> ACK=1 next edge.
4. Three back-to-back full handshakes with 8'h01, 8'h02, 8'h03 -> exactly three valid/ready transfers, in order, with no duplicates.
5. Assert RST_n low while in HOLD with SYNC_BUS=8'h77 -> outputs 0 immediately (asynchronously). After release with REQ_ASYNC still high, a new capture occurs at edge 3.
6. With PROTOCOL_CHECK_EN: drop REQ_ASYNC while in HOLD -> PROT_ERR=1 and stays set until reset. Without the macro: the same stimulus completes the transfer normally.
